axis_stream_checker: RTL and testbench

Parametrised two-stream AXI4-Stream checker for bench and on-chip self-test. It consumes two AXI4S streams in lockstep and compares them beat by beat under a bit mask, with optional numeric tolerance. It reports a sticky equal flag, beat and mismatch counters, the first mismatching beat with its data, and packet-boundary (last) misalignment. It sits at the output of a DUT path, fed by the DUT stream and a golden-model stream.

---
 rtl/axis_stream_checker_pkg.sv | 13 +
 rtl/axis_stream_checker_if.sv | 28 ++
 rtl/axis_stream_checker_beat.sv | 42 ++++
 rtl/axis_stream_checker.sv | 193 +++++++++++++++++++
 tb/tb_axis_stream_checker.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_stream_checker_pkg.sv
// Shared types and default sizes for the two-stream AXI4-Stream checker.
// The optional tolerance compare is enabled by defining AXIS_CMP_TOLERANCE_EN.
package axis_cmp_pkg;

    localparam int AXIS_CMP_CNT_WIDTH  = 32;
    localparam int AXIS_CMP_DATA_WIDTH = 64;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } cmp_state_t;

endpackage

// File: rtl/axis_stream_checker_if.sv
// Minimal AXI4-Stream bundle (valid/ready/data/last) used by the stream checker.
// No configuration macros affect this file.
interface AXI4S
    import axis_cmp_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_CMP_DATA_WIDTH
);

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;

    modport Master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport Slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );

endinterface

// File: rtl/axis_stream_checker_beat.sv
// Combinational beat comparator: masked equality, or masked absolute-difference
// tolerance when AXIS_CMP_TOLERANCE_EN is defined.
module axis_cmp_beat
    import axis_cmp_pkg::*;
#(
    parameter int                    DATA_WIDTH = AXIS_CMP_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] DATA_MASK  = '1,
    parameter logic [DATA_WIDTH-1:0] TOLERANCE  = '0
) (
    input  logic [DATA_WIDTH-1:0] data1_i,
    input  logic [DATA_WIDTH-1:0] data2_i,
    output logic                  match_o
);

    logic [DATA_WIDTH-1:0] masked1;
    logic [DATA_WIDTH-1:0] masked2;

    assign masked1 = data1_i & DATA_MASK;
    assign masked2 = data2_i & DATA_MASK;

`ifdef AXIS_CMP_TOLERANCE_EN
    logic [DATA_WIDTH:0] absDiff;

    // Subtract the smaller operand from the larger one so the extra bit never overflows.
    always_comb begin
        if (masked1 >= masked2) begin
            absDiff = {1'b0, masked1} - {1'b0, masked2};
        end else begin
            absDiff = {1'b0, masked2} - {1'b0, masked1};
        end
    end

    assign match_o = (absDiff <= {1'b0, TOLERANCE});
`else
    assign match_o = (masked1 == masked2);

    // Tolerance is meaningless for exact compares; it is only referenced at elaboration.
    if (TOLERANCE != '0) begin : gTolIgnored
    end
`endif

endmodule

// File: rtl/axis_stream_checker.sv
// Lockstep two-stream AXI4-Stream checker with sticky status, counters and first-mismatch capture.
// Tolerance compare is selected with the AXIS_CMP_TOLERANCE_EN macro.
module axis_stream_checker
    import axis_cmp_pkg::*;
#(
    parameter int                    DATA_WIDTH   = AXIS_CMP_DATA_WIDTH,
    parameter int                    CNT_WIDTH    = AXIS_CMP_CNT_WIDTH,
    parameter logic [DATA_WIDTH-1:0] DATA_MASK    = '1,
    parameter logic [DATA_WIDTH-1:0] TOLERANCE    = '0,
    parameter bit                    STOP_ON_LAST = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    AXI4S.Slave                   in1,
    AXI4S.Slave                   in2,
    output logic                  equal,
    output logic                  done,
    output logic                  last_error,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  mismatch_count,
    output logic [CNT_WIDTH-1:0]  first_mm_index,
    output logic [DATA_WIDTH-1:0] first_mm_data1,
    output logic [DATA_WIDTH-1:0] first_mm_data2,
    output logic                  first_mm_valid
);

    cmp_state_t state_q;
    cmp_state_t state_d;

    logic restart;
    logic runEnable;
    logic accept;
    logic pairMatch;
    logic stopPending;
    logic stageLastError;

    logic                  stage_q;
    logic                  stageMatch_q;
    logic                  stageLast1_q;
    logic                  stageLast2_q;
    logic [DATA_WIDTH-1:0] stageData1_q;
    logic [DATA_WIDTH-1:0] stageData2_q;

    logic                  equal_q;
    logic                  equal_d;
    logic                  lastError_q;
    logic                  lastError_d;
    logic                  firstValid_q;
    logic                  firstValid_d;
    logic [CNT_WIDTH-1:0]  beatCount_q;
    logic [CNT_WIDTH-1:0]  beatCount_d;
    logic [CNT_WIDTH-1:0]  mismatchCount_q;
    logic [CNT_WIDTH-1:0]  mismatchCount_d;
    logic [CNT_WIDTH-1:0]  firstIndex_q;
    logic [CNT_WIDTH-1:0]  firstIndex_d;
    logic [DATA_WIDTH-1:0] firstData1_q;
    logic [DATA_WIDTH-1:0] firstData1_d;
    logic [DATA_WIDTH-1:0] firstData2_q;
    logic [DATA_WIDTH-1:0] firstData2_d;

    assign restart = reset | clear;

    axis_cmp_beat #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_MASK  (DATA_MASK),
        .TOLERANCE  (TOLERANCE)
    ) uBeat (
        .data1_i (in1.data),
        .data2_i (in2.data),
        .match_o (pairMatch)
    );

    // A terminating pair sitting in the stage must block further accepts until DONE is entered.
    assign stopPending    = STOP_ON_LAST && stage_q && stageLast1_q && stageLast2_q;
    assign stageLastError = stageLast1_q ^ stageLast2_q;

    always_ff @(posedge clk) begin
        if (restart) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if ((state_q == RUN) && stopPending) begin
            state_d = DONE;
        end
    end

    always_comb begin
        runEnable = 1'b0;
        done      = 1'b0;
        case (state_q)
            RUN:     runEnable = !stopPending;
            DONE:    done      = 1'b1;
            default: ;
        endcase
    end

    // Each stream is only released when the other has a beat, so they advance in lockstep.
    assign in1.ready = runEnable & in2.valid;
    assign in2.ready = runEnable & in1.valid;
    assign accept    = runEnable & in1.valid & in2.valid;

    always_ff @(posedge clk) begin
        if (restart) begin
            stage_q      <= 1'b0;
            stageMatch_q <= 1'b1;
            stageLast1_q <= 1'b0;
            stageLast2_q <= 1'b0;
            stageData1_q <= '0;
            stageData2_q <= '0;
        end else begin
            stage_q <= accept;
            if (accept) begin
                stageMatch_q <= pairMatch;
                stageLast1_q <= in1.last;
                stageLast2_q <= in2.last;
                stageData1_q <= in1.data;
                stageData2_q <= in2.data;
            end
        end
    end

    // The current beat count is the 0-based index of the pair in the stage.
    always_comb begin
        equal_d         = equal_q;
        lastError_d     = lastError_q;
        firstValid_d    = firstValid_q;
        beatCount_d     = beatCount_q;
        mismatchCount_d = mismatchCount_q;
        firstIndex_d    = firstIndex_q;
        firstData1_d    = firstData1_q;
        firstData2_d    = firstData2_q;
        if (stage_q) begin
            if (beatCount_q != '1) begin
                beatCount_d = beatCount_q + CNT_WIDTH'(1);
            end
            if (!stageMatch_q) begin
                if (mismatchCount_q != '1) begin
                    mismatchCount_d = mismatchCount_q + CNT_WIDTH'(1);
                end
                if (!firstValid_q) begin
                    firstValid_d = 1'b1;
                    firstIndex_d = beatCount_q;
                    firstData1_d = stageData1_q;
                    firstData2_d = stageData2_q;
                end
            end
            if (stageLastError) begin
                lastError_d = 1'b1;
            end
            if (!stageMatch_q || stageLastError) begin
                equal_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            equal_q         <= 1'b1;
            lastError_q     <= 1'b0;
            firstValid_q    <= 1'b0;
            beatCount_q     <= '0;
            mismatchCount_q <= '0;
            firstIndex_q    <= '0;
            firstData1_q    <= '0;
            firstData2_q    <= '0;
        end else begin
            equal_q         <= equal_d;
            lastError_q     <= lastError_d;
            firstValid_q    <= firstValid_d;
            beatCount_q     <= beatCount_d;
            mismatchCount_q <= mismatchCount_d;
            firstIndex_q    <= firstIndex_d;
            firstData1_q    <= firstData1_d;
            firstData2_q    <= firstData2_d;
        end
    end

    assign equal          = equal_q;
    assign last_error     = lastError_q;
    assign first_mm_valid = firstValid_q;
    assign beat_count     = beatCount_q;
    assign mismatch_count = mismatchCount_q;
    assign first_mm_index = firstIndex_q;
    assign first_mm_data1 = firstData1_q;
    assign first_mm_data2 = firstData2_q;

endmodule

// File: tb/tb_axis_stream_checker.sv
// Scoreboard bench for axis_stream_checker: directed streams push expected status per pair,
// a negedge monitor pops and compares once each accepted pair reaches the outputs.
module tb_axis_stream_checker;

    logic clk = 1'b0;
    logic reset;
    logic clear;

    always #5 clk = ~clk;

    AXI4S #(.DATA_WIDTH(64)) in1If ();
    AXI4S #(.DATA_WIDTH(64)) in2If ();

    logic        equal, done, lastError, firstValid;
    logic [31:0] beatCount, mismatchCount, firstIndex;
    logic [63:0] firstData1, firstData2;

    axis_stream_checker dut (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .in1            (in1If),
        .in2            (in2If),
        .equal          (equal),
        .done           (done),
        .last_error     (lastError),
        .beat_count     (beatCount),
        .mismatch_count (mismatchCount),
        .first_mm_index (firstIndex),
        .first_mm_data1 (firstData1),
        .first_mm_data2 (firstData2),
        .first_mm_valid (firstValid)
    );

    // Masked instance: only the upper byte of a 16-bit beat is compared.
    AXI4S #(.DATA_WIDTH(16)) mIn1 ();
    AXI4S #(.DATA_WIDTH(16)) mIn2 ();

    logic        mEqual, mDone, mLastError, mFirstValid;
    logic [31:0] mBeats, mMism, mFirstIndex;
    logic [15:0] mData1, mData2;

    axis_stream_checker #(
        .DATA_WIDTH (16),
        .DATA_MASK  (16'hFF00)
    ) dutMask (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .in1            (mIn1),
        .in2            (mIn2),
        .equal          (mEqual),
        .done           (mDone),
        .last_error     (mLastError),
        .beat_count     (mBeats),
        .mismatch_count (mMism),
        .first_mm_index (mFirstIndex),
        .first_mm_data1 (mData1),
        .first_mm_data2 (mData2),
        .first_mm_valid (mFirstValid)
    );

`ifdef AXIS_CMP_TOLERANCE_EN
    AXI4S #(.DATA_WIDTH(16)) tIn1 ();
    AXI4S #(.DATA_WIDTH(16)) tIn2 ();

    logic        tEqual, tDone, tLastError, tFirstValid;
    logic [31:0] tBeats, tMism, tFirstIndex;
    logic [15:0] tData1, tData2;

    axis_stream_checker #(
        .DATA_WIDTH (16),
        .TOLERANCE  (16'd2)
    ) dutTol (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .in1            (tIn1),
        .in2            (tIn2),
        .equal          (tEqual),
        .done           (tDone),
        .last_error     (tLastError),
        .beat_count     (tBeats),
        .mismatch_count (tMism),
        .first_mm_index (tFirstIndex),
        .first_mm_data1 (tData1),
        .first_mm_data2 (tData2),
        .first_mm_valid (tFirstValid)
    );
`endif

    typedef struct packed {
        logic [31:0] beats;
        logic [31:0] mism;
        logic        eq;
        logic        lastErr;
        logic        dn;
    } expect_t;

    expect_t expQ[$];
    int      testsRun    = 0;
    int      testsFailed = 0;
    bit      monAcc1     = 1'b0;
    bit      monAcc2     = 1'b0;

    function automatic expect_t mkExp(input int b, input int m, input bit eq, input bit le, input bit dn);
        expect_t e;
        e.beats   = 32'(b);
        e.mism    = 32'(m);
        e.eq      = eq;
        e.lastErr = le;
        e.dn      = dn;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        testsRun++;
        if (actual !== required) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " equal"},          64'(equal),         64'd1);
        checkOutput({tag, " done"},           64'(done),          64'd0);
        checkOutput({tag, " last_error"},     64'(lastError),     64'd0);
        checkOutput({tag, " beat_count"},     64'(beatCount),     64'd0);
        checkOutput({tag, " mismatch_count"}, 64'(mismatchCount), 64'd0);
        checkOutput({tag, " first_mm_valid"}, 64'(firstValid),    64'd0);
        checkOutput({tag, " first_mm_index"}, 64'(firstIndex),    64'd0);
        checkOutput({tag, " first_mm_data1"}, firstData1,         64'd0);
        checkOutput({tag, " first_mm_data2"}, firstData2,         64'd0);
    endtask

    // Results for a pair accepted at edge N are visible after edge N+1, two negedges later.
    initial begin
        expect_t e;
        bit      accNow;
        bit      restartNow;
        forever begin
            @(negedge clk);
            accNow     = in1If.valid && in1If.ready && in2If.valid && in2If.ready && !reset && !clear;
            restartNow = reset || clear;
            if (monAcc2) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL scoreboard underflow: got an accepted pair, expected none");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sb beat_count",     64'(beatCount),     64'(e.beats));
                    checkOutput("sb mismatch_count", 64'(mismatchCount), 64'(e.mism));
                    checkOutput("sb equal",          64'(equal),         64'(e.eq));
                    checkOutput("sb last_error",     64'(lastError),     64'(e.lastErr));
                    checkOutput("sb done",           64'(done),          64'(e.dn));
                end
            end
            monAcc2 = monAcc1 && !restartNow;
            monAcc1 = accNow;
        end
    end

    task automatic applyStimulus(input logic [63:0] d1, input logic [63:0] d2,
                                 input logic l1, input logic l2, input expect_t e);
        bit ok;
        ok = 1'b0;
        expQ.push_back(e);
        in1If.valid = 1'b1; in1If.data = d1; in1If.last = l1;
        in2If.valid = 1'b1; in2If.data = d2; in2If.last = l2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in1If.ready && in2If.ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL handshake timeout: got no ready, expected ready within 20 cycles");
            void'(expQ.pop_back());
        end
        @(posedge clk); #1;
        in1If.valid = 1'b0;
        in2If.valid = 1'b0;
        in1If.last  = 1'b0;
        in2If.last  = 1'b0;
    endtask

    task automatic drainScoreboard();
        for (int i = 0; i < 20; i++) begin
            if (expQ.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
        expQ.delete();
        @(posedge clk); #1;
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic applyMaskBeat(input logic [15:0] d1, input logic [15:0] d2, input logic l);
        mIn1.valid = 1'b1; mIn1.data = d1; mIn1.last = l;
        mIn2.valid = 1'b1; mIn2.data = d2; mIn2.last = l;
        @(posedge clk); #1;
        mIn1.valid = 1'b0; mIn2.valid = 1'b0;
        @(posedge clk); #1;
    endtask

`ifdef AXIS_CMP_TOLERANCE_EN
    task automatic applyTolBeat(input logic [15:0] d1, input logic [15:0] d2, input logic l);
        tIn1.valid = 1'b1; tIn1.data = d1; tIn1.last = l;
        tIn2.valid = 1'b1; tIn2.data = d2; tIn2.last = l;
        @(posedge clk); #1;
        tIn1.valid = 1'b0; tIn2.valid = 1'b0;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        in1If.valid = 1'b0; in1If.data = '0; in1If.last = 1'b0;
        in2If.valid = 1'b0; in2If.data = '0; in2If.last = 1'b0;
        mIn1.valid = 1'b0; mIn1.data = '0; mIn1.last = 1'b0;
        mIn2.valid = 1'b0; mIn2.data = '0; mIn2.last = 1'b0;
`ifdef AXIS_CMP_TOLERANCE_EN
        tIn1.valid = 1'b0; tIn1.data = '0; tIn1.last = 1'b0;
        tIn2.valid = 1'b0; tIn2.data = '0; tIn2.last = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkResetState("reset");
        @(posedge clk); #1;

        // Identical streams 0..7, both last on beat 7.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(64'(i), 64'(i), i == 7, i == 7, mkExp(i + 1, 0, 1'b1, 1'b0, i == 7));
        end
        drainScoreboard();
        in1If.valid = 1'b1;
        in2If.valid = 1'b1;
        @(negedge clk);
        checkOutput("in1 ready in DONE", 64'(in1If.ready), 64'd0);
        checkOutput("in2 ready in DONE", 64'(in2If.ready), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        in1If.valid = 1'b0;
        in2If.valid = 1'b0;
        @(negedge clk);
        checkOutput("beat_count frozen in DONE", 64'(beatCount), 64'd8);
        checkOutput("done held", 64'(done), 64'd1);
        @(posedge clk); #1;
        pulseClear();
        @(negedge clk);
        checkResetState("clear after done");
        @(posedge clk); #1;

        // Single mismatch at beat 3.
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                applyStimulus(64'h33, 64'h34, 1'b0, 1'b0, mkExp(4, 1, 1'b0, 1'b0, 1'b0));
            end else begin
                applyStimulus(64'(i * 17), 64'(i * 17), i == 5, i == 5,
                              mkExp(i + 1, (i > 3) ? 1 : 0, i < 3, 1'b0, i == 5));
            end
        end
        drainScoreboard();
        checkOutput("first_mm_valid", 64'(firstValid), 64'd1);
        checkOutput("first_mm_index", 64'(firstIndex), 64'd3);
        checkOutput("first_mm_data1", firstData1, 64'h33);
        checkOutput("first_mm_data2", firstData2, 64'h34);
        pulseClear();

        // Handshake skew: in1 waits five cycles for in2.
        in1If.valid = 1'b1; in1If.data = 64'hA; in1If.last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("skew in1 ready", 64'(in1If.ready), 64'd0);
            @(posedge clk); #1;
        end
        expQ.push_back(mkExp(1, 0, 1'b1, 1'b0, 1'b0));
        in2If.valid = 1'b1; in2If.data = 64'hA; in2If.last = 1'b0;
        @(negedge clk);
        checkOutput("skew in1 ready at match", 64'(in1If.ready), 64'd1);
        @(posedge clk); #1;
        in1If.valid = 1'b0;
        in2If.valid = 1'b0;
        @(negedge clk);
        checkOutput("skew latency beat_count", 64'(beatCount), 64'd0);
        drainScoreboard();
        pulseClear();

        // Last misalignment: in1 ends on beat 4, in2 on beat 5.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(64'(256 + i), 64'(256 + i), i == 4, i == 5,
                          mkExp(i + 1, 0, i < 4, i >= 4, 1'b0));
        end
        drainScoreboard();
        pulseClear();

        // Three mismatches, then clear together with a valid pair.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(64'(i), 64'(i + 128), 1'b0, 1'b0, mkExp(i + 1, i + 1, 1'b0, 1'b0, 1'b0));
        end
        drainScoreboard();
        checkOutput("mismatch_count before clear", 64'(mismatchCount), 64'd3);
        in1If.valid = 1'b1; in1If.data = 64'd5;
        in2If.valid = 1'b1; in2If.data = 64'd5;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        in1If.valid = 1'b0;
        in2If.valid = 1'b0;
        @(negedge clk);
        checkResetState("clear with pair");
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("discarded pair not counted", 64'(beatCount), 64'd0);
        @(posedge clk); #1;
        applyStimulus(64'd9, 64'd9, 1'b0, 1'b0, mkExp(1, 0, 1'b1, 1'b0, 1'b0));
        applyStimulus(64'd10, 64'd10, 1'b1, 1'b1, mkExp(2, 0, 1'b1, 1'b0, 1'b1));
        drainScoreboard();

        // Masked compare on the 16-bit instance.
        applyMaskBeat(16'h12AB, 16'h12CD, 1'b0);
        checkOutput("mask low byte ignored equal", 64'(mEqual), 64'd1);
        checkOutput("mask low byte ignored mism", 64'(mMism), 64'd0);
        applyMaskBeat(16'h12AB, 16'h13AB, 1'b1);
        checkOutput("mask high byte mism", 64'(mMism), 64'd1);
        checkOutput("mask high byte equal", 64'(mEqual), 64'd0);
        checkOutput("mask first index", 64'(mFirstIndex), 64'd1);
        checkOutput("mask done", 64'(mDone), 64'd1);

`ifdef AXIS_CMP_TOLERANCE_EN
        applyTolBeat(16'd100, 16'd102, 1'b0);
        checkOutput("tol diff 2 mism", 64'(tMism), 64'd0);
        applyTolBeat(16'd100, 16'd103, 1'b0);
        checkOutput("tol diff 3 mism", 64'(tMism), 64'd1);
        applyTolBeat(16'd103, 16'd101, 1'b1);
        checkOutput("tol reversed diff 2 mism", 64'(tMism), 64'd1);
        checkOutput("tol first index", 64'(tFirstIndex), 64'd1);
        checkOutput("tol first data2", 64'(tData2), 64'd103);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
